// File: rtl/mm_stream_sequencer_pkg.sv
// Shared types and default dimensions for the matrix-multiply stream front end.
package mm_stream_sequencer_pkg;

  localparam int unsigned MM_SIZE   = 12;
  localparam int unsigned MM_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mm_stream_sequencer_if.sv
// AXI-Stream bundle with row/column side-band tags for the mm datapath.
interface mm_stream_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SIZE   = 12
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [SIZE-1:0]   row_idx;
  logic [SIZE-1:0]   col_idx;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output row_idx,
    output col_idx,
    input  tready
  );

  // Upstream producers carry no tags, so the slave view is plain data/valid/ready.
  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/mm_stream_sequencer_counter.sv
// Wrap counter: counts 0..max-1 on en, wraps to 0; done flags the last value.
module counter #(
  parameter int unsigned SIZE = 12
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            clr,
  input  logic            en,
  input  logic [SIZE-1:0] max,
  output logic [SIZE-1:0] count,
  output logic            done
);

  logic [SIZE-1:0] last;

  assign last = max - SIZE'(1);
  assign done = (count == last);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= done ? '0 : count + SIZE'(1);
    end
  end

endmodule

// File: rtl/mm_stream_sequencer.sv
// Streams rows*cols beats through a one-deep slice, tagging each with its
// row/column index and tlast at the end of every row.
module mm_stream_sequencer
  import mm_stream_sequencer_pkg::*;
#(
  parameter int unsigned SIZE   = MM_SIZE,
  parameter int unsigned DATA_W = MM_DATA_W
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic [SIZE-1:0]        rows,
  input  logic [SIZE-1:0]        cols,
  output logic                   busy,
  output logic                   done,
  mm_stream_sequencer_if.slave   s_axis,
  mm_stream_sequencer_if.master  m_axis
);

  state_t          state_q;
  state_t          state_d;
  logic [SIZE-1:0] rows_q;
  logic [SIZE-1:0] cols_q;
  logic [SIZE-1:0] col_cnt;
  logic [SIZE-1:0] row_cnt;
  logic            col_last;
  logic            row_last;
  logic            job_clr;
  logic            done_d;
  logic            accept;
  logic            final_beat;

  // Slice may take a new beat whenever its current one is leaving this cycle.
  assign s_axis.tready = (state_q == S_RUN) && (!m_axis.tvalid || m_axis.tready);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign final_beat    = accept && col_last && row_last;
  assign busy          = (state_q != S_IDLE);

  counter #(.SIZE(SIZE)) u_col_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (job_clr),
    .en      (accept),
    .max     (cols_q),
    .count   (col_cnt),
    .done    (col_last)
  );

  counter #(.SIZE(SIZE)) u_row_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (job_clr),
    .en      (accept && col_last),
    .max     (rows_q),
    .count   (row_cnt),
    .done    (row_last)
  );

  always_comb begin
    state_d = state_q;
    job_clr = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (rows != '0 && cols != '0) begin
            state_d = S_RUN;
            job_clr = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (final_beat) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (m_axis.tvalid && m_axis.tready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      done    <= 1'b0;
      rows_q  <= '0;
      cols_q  <= '0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (job_clr) begin
        rows_q <= rows;
        cols_q <= cols;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis.tdata   <= '0;
      m_axis.tvalid  <= 1'b0;
      m_axis.tlast   <= 1'b0;
      m_axis.row_idx <= '0;
      m_axis.col_idx <= '0;
    end else if (accept) begin
      m_axis.tdata   <= s_axis.tdata;
      m_axis.tvalid  <= 1'b1;
      m_axis.tlast   <= col_last;
      m_axis.row_idx <= row_cnt;
      m_axis.col_idx <= col_cnt;
    end else if (m_axis.tready) begin
      m_axis.tvalid  <= 1'b0;
    end
  end

endmodule
